// File: rtl/blake2b_msg_packer_if.sv
// Packer stream bundle: beat input (i_*) plus packed-block output (o_*), named from the packer's side.
// slave = packer, master = source/sink driving the beats and consuming the block.
interface blake2b_msg_packer_if #(
    parameter int IN_BYTS = 8,
    parameter int MAX_LEN = 144
);
    localparam int MW = (IN_BYTS > 1) ? $clog2(IN_BYTS) : 1;

    logic [IN_BYTS*8-1:0] i_dat;
    logic                 i_val;
    logic                 i_sop;
    logic                 i_eop;
    logic [MW-1:0]        i_mod;
    logic                 o_rdy;

    logic [MAX_LEN*8-1:0] o_dat;
    logic [7:0]           o_byte_len;
    logic                 o_val;
    logic                 o_sop;
    logic                 o_eop;
    logic                 o_err;
    logic                 i_rdy;

    modport slave (
        input  i_dat, i_val, i_sop, i_eop, i_mod, i_rdy,
        output o_rdy, o_dat, o_byte_len, o_val, o_sop, o_eop, o_err
    );

    modport master (
        output i_dat, i_val, i_sop, i_eop, i_mod, i_rdy,
        input  o_rdy, o_dat, o_byte_len, o_val, o_sop, o_eop, o_err
    );
endinterface

// File: rtl/blake2b_msg_packer.sv
// Packs a beat stream into one zero-padded MAX_LEN-byte block for the BLAKE2b core; block valid one cycle after eop.
// o_rdy drops while a block is held, until the downstream i_rdy handshake; bytes beyond MAX_LEN are dropped and flagged.
module blake2b_msg_packer #(
    parameter int IN_BYTS = 8,
    parameter int MAX_LEN = 144
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    blake2b_msg_packer_if.slave  io_bus
);
    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rst_q;
    logic [MAX_LEN*8-1:0] r_buf;
    logic [7:0]           r_cnt;
    logic                 r_err;

    logic                 w_rdy;
    logic                 w_xfer;
    logic                 w_start;
    logic                 w_append;
    logic [8:0]           w_nv;
    logic [8:0]           w_base;
    logic [8:0]           w_end;
    logic                 w_ovf;
    logic [MAX_LEN*8-1:0] w_buf_nxt;

    // Single flop so o_rdy rises on the first edge after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_rst_q <= 1'b1;
        else       r_rst_q <= 1'b0;
    end

    assign w_rdy  = !r_rst_q && (r_state != HOLD);
    assign w_xfer = io_bus.i_val && w_rdy;

    always_comb begin
        w_nv = 9'(IN_BYTS);
        if (io_bus.i_eop && (io_bus.i_mod != '0))
            w_nv = 9'(io_bus.i_mod);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_append    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer && io_bus.i_sop) begin
                    w_start     = 1'b1;
                    w_state_nxt = io_bus.i_eop ? HOLD : FILL;
                end
            end
            FILL: begin
                if (w_xfer) begin
                    if (io_bus.i_sop) w_start  = 1'b1;
                    else              w_append = 1'b1;
                    w_state_nxt = io_bus.i_eop ? HOLD : FILL;
                end
            end
            HOLD: begin
                if (io_bus.i_rdy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_base = w_start ? 9'd0 : {1'b0, r_cnt};
    assign w_end  = w_base + w_nv;
    assign w_ovf  = (w_end > 9'(MAX_LEN));

    // Only valid bytes landing below MAX_LEN are written; everything else keeps the cleared zero.
    always_comb begin
        w_buf_nxt = w_start ? '0 : r_buf;
        for (int j = 0; j < MAX_LEN; j++) begin
            int k;
            k = j - int'(w_base);
            if ((k >= 0) && (k < int'(w_nv)))
                w_buf_nxt[8*j +: 8] = io_bus.i_dat[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (w_start || w_append) begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_ovf ? 8'(MAX_LEN) : w_end[7:0];
            r_err <= (w_start ? 1'b0 : r_err) | w_ovf;
        end
    end

    assign io_bus.o_rdy      = w_rdy;
    assign io_bus.o_dat      = r_buf;
    assign io_bus.o_byte_len = r_cnt;
    assign io_bus.o_val      = (r_state == HOLD);
    assign io_bus.o_sop      = (r_state == HOLD);
    assign io_bus.o_eop      = (r_state == HOLD);
    assign io_bus.o_err      = r_err;
endmodule

// File: tb/tb_blake2b_msg_packer.sv
// Directed bench for blake2b_msg_packer with IN_BYTS=8, MAX_LEN=144.
module tb_blake2b_msg_packer;
    localparam int IB = 8;
    localparam int ML = 144;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_stall = 0;

    blake2b_msg_packer_if #(.IN_BYTS(IB), .MAX_LEN(ML)) io ();
    blake2b_msg_packer #(.IN_BYTS(IB), .MAX_LEN(ML)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(io)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_dat(input string tag, input logic [ML*8-1:0] obs, input logic [ML*8-1:0] exp);
        int idx;
        idx = 0;
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            for (int j = ML - 1; j >= 0; j--)
                if (obs[8*j +: 8] !== exp[8*j +: 8]) idx = j;
            $error("FAIL %s: byte %0d observed %h expected %h", tag, idx, obs[8*idx +: 8], exp[8*idx +: 8]);
        end
    endtask

    function automatic logic [7:0] pat(input int seed, input int j);
        return 8'(seed * 37 + j + 1);
    endfunction

    function automatic logic [IB*8-1:0] beat_dat(input int seed, input int b);
        logic [IB*8-1:0] d;
        for (int k = 0; k < IB; k++) d[8*k +: 8] = pat(seed, IB * b + k);
        return d;
    endfunction

    function automatic logic [ML*8-1:0] exp_dat(input int seed, input int len);
        logic [ML*8-1:0] e;
        e = '0;
        for (int j = 0; j < ML; j++)
            if (j < len) e[8*j +: 8] = pat(seed, j);
        return e;
    endfunction

    task automatic beat(input logic [IB*8-1:0] d, input logic s, input logic e, input logic [2:0] m);
        io.i_dat = d;
        io.i_val = 1'b1;
        io.i_sop = s;
        io.i_eop = e;
        io.i_mod = m;
        if (!io.o_rdy) n_stall++;
        tick();
        io.i_val = 1'b0;
        io.i_sop = 1'b0;
        io.i_eop = 1'b0;
    endtask

    task automatic send_msg(input int seed, input int nbytes);
        int nb;
        nb = (nbytes + IB - 1) / IB;
        for (int b = 0; b < nb; b++)
            beat(beat_dat(seed, b), b == 0, b == nb - 1, 3'(nbytes % IB));
    endtask

    task automatic check_out(input string tag, input int seed, input int len, input int blen, input logic err);
        chk({tag, "_val"}, 64'(io.o_val), 64'd1);
        chk({tag, "_sop"}, 64'(io.o_sop), 64'd1);
        chk({tag, "_eop"}, 64'(io.o_eop), 64'd1);
        chk({tag, "_len"}, 64'(io.o_byte_len), 64'(blen));
        chk({tag, "_err"}, 64'(io.o_err), 64'(err));
        chk_dat({tag, "_dat"}, io.o_dat, exp_dat(seed, len));
    endtask

    task automatic release_blk(input string tag);
        tick();
        chk({tag, "_done"}, 64'(io.o_val), 64'd0);
    endtask

    initial begin
        logic [ML*8-1:0] e;
        io.i_dat = '0;
        io.i_val = 1'b0;
        io.i_sop = 1'b0;
        io.i_eop = 1'b0;
        io.i_mod = '0;
        io.i_rdy = 1'b1;

        // Reset state and o_rdy release timing
        tick();
        tick();
        chk("rst_rdy", 64'(io.o_rdy), 64'd0);
        chk("rst_val", 64'(io.o_val), 64'd0);
        chk("rst_len", 64'(io.o_byte_len), 64'd0);
        chk("rst_err", 64'(io.o_err), 64'd0);
        chk_dat("rst_dat", io.o_dat, '0);
        rst = 1'b0;
        #1;
        chk("rdy_before_edge", 64'(io.o_rdy), 64'd0);
        tick();
        chk("rdy_after_edge", 64'(io.o_rdy), 64'd1);

        // Non-sop beat in IDLE is discarded
        beat(beat_dat(0, 0), 1'b0, 1'b1, 3'd0);
        chk("idle_discard_val", 64'(io.o_val), 64'd0);
        tick();
        chk("idle_discard_val2", 64'(io.o_val), 64'd0);

        // "abc": invalid upper bytes carry junk that must not appear
        beat(64'hA5A5_A5A5_A5_636261, 1'b1, 1'b1, 3'd3);
        e = '0;
        e[23:0] = 24'h636261;
        chk("abc_val", 64'(io.o_val), 64'd1);
        chk("abc_len", 64'(io.o_byte_len), 64'd3);
        chk("abc_err", 64'(io.o_err), 64'd0);
        chk("abc_rdy", 64'(io.o_rdy), 64'd0);
        chk_dat("abc_dat", io.o_dat, e);
        release_blk("abc");

        send_msg(1, 144);
        check_out("m144", 1, 144, 144, 1'b0);
        release_blk("m144");

        send_msg(2, 129);
        check_out("m129", 2, 129, 129, 1'b0);
        release_blk("m129");

        // Overflow: 160 bytes, all beats accepted, truncated to 144
        n_stall = 0;
        send_msg(3, 160);
        chk("ovf_accept", 64'(n_stall), 64'd0);
        check_out("m160", 3, 144, 144, 1'b1);
        release_blk("m160");

        // Backpressure in HOLD with the next message's first beat waiting
        io.i_rdy = 1'b0;
        send_msg(4, 20);
        check_out("bp", 4, 20, 20, 1'b0);
        io.i_dat = beat_dat(5, 0);
        io.i_val = 1'b1;
        io.i_sop = 1'b1;
        io.i_eop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_val", 64'(io.o_val), 64'd1);
            chk("bp_hold_rdy", 64'(io.o_rdy), 64'd0);
            chk("bp_hold_len", 64'(io.o_byte_len), 64'd20);
            chk_dat("bp_hold_dat", io.o_dat, exp_dat(4, 20));
        end
        io.i_rdy = 1'b1;
        tick();
        chk("bp_hs_val", 64'(io.o_val), 64'd0);
        chk("bp_hs_rdy", 64'(io.o_rdy), 64'd1);
        send_msg(5, 16);
        check_out("bp2", 5, 16, 16, 1'b0);
        release_blk("bp2");

        // sop restart after 3 beats abandons the first message
        for (int b = 0; b < 3; b++) beat(beat_dat(6, b), b == 0, 1'b0, 3'd0);
        chk("rs_nout", 64'(io.o_val), 64'd0);
        send_msg(7, 24);
        check_out("rs", 7, 24, 24, 1'b0);
        release_blk("rs");

        // Reset pulse after 5 beats
        for (int b = 0; b < 5; b++) beat(beat_dat(8, b), b == 0, 1'b0, 3'd0);
        rst = 1'b1;
        #1;
        chk("mrst_rdy", 64'(io.o_rdy), 64'd0);
        chk("mrst_val", 64'(io.o_val), 64'd0);
        chk("mrst_len", 64'(io.o_byte_len), 64'd0);
        chk_dat("mrst_dat", io.o_dat, '0);
        tick();
        rst = 1'b0;
        tick();
        chk("mrst_rdy2", 64'(io.o_rdy), 64'd1);
        chk("mrst_val2", 64'(io.o_val), 64'd0);
        send_msg(9, 13);
        check_out("mrst_next", 9, 13, 13, 1'b0);
        release_blk("mrst_next");

        // Reset during HOLD drops the held block
        io.i_rdy = 1'b0;
        send_msg(10, 8);
        chk("hrst_pre_val", 64'(io.o_val), 64'd1);
        rst = 1'b1;
        #1;
        chk("hrst_val", 64'(io.o_val), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        io.i_rdy = 1'b1;
        tick();
        chk("hrst_after_val", 64'(io.o_val), 64'd0);
        chk("hrst_after_rdy", 64'(io.o_rdy), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
